// File: rtl/time_unit_counter.sv
// Wrapping time-unit counter (hours/minutes/seconds digit pair) with carry-in,
// manual adjust with auto-repeat, synchronous load and a registered BCD display word.
module time_unit_counter #(
    parameter int MODULUS = 24,
    parameter int CW      = 6,
    parameter int AMPM_EN = 1,
    parameter int REP_DLY = 500,
    parameter int REP_PER = 100
) (
    input  logic          CP,
    input  logic          RST,
    input  logic          CARRY,
    input  logic          CH,
    input  logic          ADJMODE,
    input  logic          STYLE,
    input  logic          LOAD,
    input  logic [CW-1:0] LOAD_VAL,
    output logic [CW-1:0] value,
    output logic [15:0]   data,
    output logic          carry_out
);

    localparam int            RMAX      = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int            RW        = $clog2(RMAX + 1);
    localparam logic [CW-1:0] TOP       = CW'(MODULUS - 1);
    localparam bit            TWELVE_OK = (AMPM_EN != 0) && (MODULUS == 24);

    // IDLE means "not armed": holding CH without a fresh rising edge never repeats
    typedef enum logic [1:0] {PH_IDLE, PH_DELAY, PH_REPEAT} phase_t;

    phase_t        phase, phase_nx;
    logic [RW-1:0] rep_cnt, rep_cnt_nx;
    logic          carry_q, ch_q;
    logic          carry_ev, ch_ev, rep_step, step;
    logic [CW-1:0] value_nx, step_val;
    logic          carry_out_nx;
    logic [6:0]    disp;
    logic [3:0]    code, tens, ones;

    assign carry_ev = CARRY & ~carry_q;
    assign ch_ev    = CH & ~ch_q;
    assign step     = ch_ev | rep_step;

    always_comb begin
        phase_nx   = phase;
        rep_cnt_nx = rep_cnt;
        rep_step   = 1'b0;
        if (!CH) begin
            phase_nx   = PH_IDLE;
            rep_cnt_nx = '0;
        end else if (ch_ev) begin
            phase_nx   = PH_DELAY;
            rep_cnt_nx = '0;
        end else begin
            case (phase)
                PH_DELAY: begin
                    if (rep_cnt == RW'(REP_DLY - 1)) begin
                        rep_step   = 1'b1;
                        phase_nx   = PH_REPEAT;
                        rep_cnt_nx = '0;
                    end else begin
                        rep_cnt_nx = rep_cnt + RW'(1);
                    end
                end
                PH_REPEAT: begin
                    if (rep_cnt == RW'(REP_PER - 1)) begin
                        rep_step   = 1'b1;
                        rep_cnt_nx = '0;
                    end else begin
                        rep_cnt_nx = rep_cnt + RW'(1);
                    end
                end
                default: rep_cnt_nx = '0;
            endcase
        end
    end

    always_comb begin
        if (ADJMODE) step_val = (value == '0) ? TOP : value - CW'(1);
        else         step_val = (value == TOP) ? '0 : value + CW'(1);
    end

    always_comb begin
        value_nx     = value;
        carry_out_nx = 1'b0;
        if (LOAD) begin
            value_nx = (32'(LOAD_VAL) < MODULUS) ? LOAD_VAL : '0;
        end else if (carry_ev) begin
            if (value == TOP) begin
                value_nx     = '0;
                carry_out_nx = 1'b1;
            end else begin
                value_nx = value + CW'(1);
            end
        end else if (step) begin
            value_nx = step_val;
        end
    end

    always_comb begin
        disp = 7'(value);
        code = 4'hc;
        if (TWELVE_OK && STYLE) begin
            if (disp < 7'd12) begin
                code = 4'ha;
            end else begin
                code = 4'hb;
                if (disp > 7'd12) disp = disp - 7'd12;
            end
        end
        tens = 4'(disp / 7'd10);
        ones = 4'(disp % 7'd10);
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            value     <= '0;
            data      <= 16'hcc00;
            carry_out <= 1'b0;
            carry_q   <= 1'b1;
            ch_q      <= 1'b1;
            phase     <= PH_IDLE;
            rep_cnt   <= '0;
        end else begin
            value     <= value_nx;
            data      <= {code, 4'hc, tens, ones};
            carry_out <= carry_out_nx;
            carry_q   <= CARRY;
            ch_q      <= CH;
            phase     <= phase_nx;
            rep_cnt   <= rep_cnt_nx;
        end
    end

endmodule

// File: tb/tb_time_unit_counter.sv
// Self-checking bench for time_unit_counter: a default 24-hour instance and a
// MODULUS=60 instance sharing inputs, checked against a cycle-level behavioural model.
module tb_time_unit_counter;

    localparam int REP_DLY = 500;
    localparam int REP_PER = 100;

    logic        CP = 1'b0;
    logic        RST, CARRY, CH, ADJMODE, STYLE, LOAD;
    logic [5:0]  LOAD_VAL;
    logic [5:0]  value, value60;
    logic [15:0] data, data60;
    logic        carry_out, carry_out60;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: index 0 is the 24-hour instance, index 1 the MODULUS=60 instance
    int          mod_of[2] = '{24, 60};
    int          m_val[2];
    logic [15:0] m_data[2];
    bit          m_cout[2];
    bit          m_cq, m_chq;
    int          m_hold;

    always #5 CP = ~CP;

    time_unit_counter dut (
        .CP(CP), .RST(RST), .CARRY(CARRY), .CH(CH), .ADJMODE(ADJMODE), .STYLE(STYLE),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .value(value), .data(data), .carry_out(carry_out)
    );

    time_unit_counter #(.MODULUS(60), .CW(6), .AMPM_EN(1), .REP_DLY(REP_DLY), .REP_PER(REP_PER)) dut60 (
        .CP(CP), .RST(RST), .CARRY(CARRY), .CH(CH), .ADJMODE(ADJMODE), .STYLE(STYLE),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .value(value60), .data(data60), .carry_out(carry_out60)
    );

    function automatic logic [15:0] word(input int v, input bit twelve);
        int d;
        logic [3:0] c;
        c = 4'hc;
        d = v;
        if (twelve) begin
            c = (v < 12) ? 4'ha : 4'hb;
            d = (v > 12) ? v - 12 : v;
        end
        return {c, 4'hc, 4'(d / 10), 4'(d % 10)};
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUTs.
    task automatic tick();
        bit cev, chev, stp;
        cev  = CARRY && !m_cq;
        chev = CH && !m_chq;
        if (!CH)            m_hold = -1;
        else if (chev)      m_hold = 0;
        else if (m_hold >= 0) m_hold++;
        stp = (m_hold == 0) ||
              (m_hold >= REP_DLY && ((m_hold - REP_DLY) % REP_PER) == 0);
        for (int k = 0; k < 2; k++) begin
            m_data[k] = word(m_val[k], (k == 0) && STYLE);
            m_cout[k] = 1'b0;
            if (RST) begin
                m_val[k]  = 0;
                m_data[k] = 16'hcc00;
            end else if (LOAD) begin
                m_val[k] = (int'(LOAD_VAL) < mod_of[k]) ? int'(LOAD_VAL) : 0;
            end else if (cev) begin
                if (m_val[k] == mod_of[k] - 1) begin
                    m_val[k]  = 0;
                    m_cout[k] = 1'b1;
                end else begin
                    m_val[k]++;
                end
            end else if (stp) begin
                m_val[k] = ADJMODE ? (m_val[k] + mod_of[k] - 1) % mod_of[k]
                                   : (m_val[k] + 1) % mod_of[k];
            end
        end
        if (RST) begin
            m_cq   = 1'b1;
            m_chq  = 1'b1;
            m_hold = -1;
        end else begin
            m_cq  = CARRY;
            m_chq = CH;
        end
        @(posedge CP);
        #1;
    endtask

    task automatic load(input int v);
        LOAD     = 1'b1;
        LOAD_VAL = 6'(v);
        tick();
        LOAD     = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; CARRY = 1'b1; CH = 1'b1; ADJMODE = 1'b0; STYLE = 1'b0;
        LOAD = 1'b0; LOAD_VAL = '0;
        m_val = '{0, 0}; m_cq = 1'b1; m_chq = 1'b1; m_hold = -1;
        tick(); tick();
        n_cmp++; if (value !== 6'd0) begin n_bad++; $display("FAIL reset_value got=%0d want=0", value); end
        n_cmp++; if (data !== 16'hcc00) begin n_bad++; $display("FAIL reset_data got=%h want=cc00", data); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL reset_carry_out got=%b want=0", carry_out); end
        n_cmp++; if (value60 !== 6'd0) begin n_bad++; $display("FAIL reset_value60 got=%0d want=0", value60); end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (value !== 6'd0) begin n_bad++; $display("FAIL reset_held_inputs got=%0d want=0", value); end
        CARRY = 1'b0; CH = 1'b0;
        tick();
    endtask

    task automatic test_carry_wrap();
        load(23);
        CARRY = 1'b0; tick();
        CARRY = 1'b1; tick();
        n_cmp++; if (value !== 6'd0) begin n_bad++; $display("FAIL carry_wrap_value got=%0d want=0", value); end
        n_cmp++; if (carry_out !== 1'b1) begin n_bad++; $display("FAIL carry_wrap_pulse got=%b want=1", carry_out); end
        n_cmp++; if (value60 !== 6'd24) begin n_bad++; $display("FAIL carry_mod60_value got=%0d want=24", value60); end
        tick();
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL carry_wrap_pulse_end got=%b want=0", carry_out); end
        n_cmp++; if (data !== 16'hcc00) begin n_bad++; $display("FAIL carry_wrap_data got=%h want=cc00", data); end
        CARRY = 1'b0; tick();
    endtask

    task automatic test_adjust_down();
        load(0);
        STYLE = 1'b1; ADJMODE = 1'b1; CH = 1'b0; tick();
        CH = 1'b1; tick();
        n_cmp++; if (value !== 6'd23) begin n_bad++; $display("FAIL adjust_down_wrap got=%0d want=23", value); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL adjust_no_carry got=%b want=0", carry_out); end
        CH = 1'b0; tick();
        n_cmp++; if (data !== 16'hbc11) begin n_bad++; $display("FAIL adjust_down_data got=%h want=bc11", data); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL adjust_no_carry2 got=%b want=0", carry_out); end
        STYLE = 1'b0; ADJMODE = 1'b0;
    endtask

    task automatic test_auto_repeat();
        int steps[$];
        logic [5:0] prev;
        load(5);
        ADJMODE = 1'b0; CH = 1'b0; tick();
        for (int i = 0; i < 800; i++) begin
            prev = value;
            CH = 1'b1;
            tick();
            if (value !== prev) steps.push_back(i);
        end
        n_cmp++; if (value !== 6'd9) begin n_bad++; $display("FAIL repeat_final got=%0d want=9", value); end
        n_cmp++; if (value !== 6'(m_val[0])) begin n_bad++; $display("FAIL repeat_model got=%0d want=%0d", value, m_val[0]); end
        n_cmp++;
        if (steps.size() != 4 || steps[0] != 0 || steps[1] != 500 || steps[2] != 600 || steps[3] != 700) begin
            n_bad++; $display("FAIL repeat_step_cycles got=%p want=0,500,600,700", steps);
        end
        CH = 1'b0; tick();
        n_cmp++; if (value !== 6'd9) begin n_bad++; $display("FAIL repeat_release got=%0d want=9", value); end
    endtask

    task automatic test_priority();
        load(10);
        CARRY = 1'b0; CH = 1'b0; tick();
        CARRY = 1'b1; CH = 1'b1; tick();
        n_cmp++; if (value !== 6'd11) begin n_bad++; $display("FAIL priority_carry_over_ch got=%0d want=11", value); end
        CARRY = 1'b0; CH = 1'b0; tick();
        CARRY = 1'b1; LOAD = 1'b1; LOAD_VAL = 6'd3; tick();
        LOAD = 1'b0;
        n_cmp++; if (value !== 6'd3) begin n_bad++; $display("FAIL priority_load_over_carry got=%0d want=3", value); end
        CARRY = 1'b0; tick();
    endtask

    task automatic test_style_sweep();
        int          vals[5] = '{0, 11, 12, 13, 23};
        logic [15:0] want[5] = '{16'hac00, 16'hac11, 16'hbc12, 16'hbc01, 16'hbc11};
        STYLE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load(vals[i]);
            tick();
            n_cmp++;
            if (data !== want[i]) begin
                n_bad++; $display("FAIL style_sweep_%0d got=%h want=%h", vals[i], data, want[i]);
            end
        end
        n_cmp++; if (data60 !== 16'hcc23) begin n_bad++; $display("FAIL style_mod60_24h got=%h want=cc23", data60); end
        STYLE = 1'b0;
    endtask

    task automatic test_mod60();
        load(59);
        CARRY = 1'b0; tick();
        CARRY = 1'b1; tick();
        n_cmp++; if (value60 !== 6'd0) begin n_bad++; $display("FAIL mod60_wrap got=%0d want=0", value60); end
        n_cmp++; if (carry_out60 !== 1'b1) begin n_bad++; $display("FAIL mod60_pulse got=%b want=1", carry_out60); end
        n_cmp++; if (value !== 6'd1) begin n_bad++; $display("FAIL mod24_load59_then_carry got=%0d want=1", value); end
        CARRY = 1'b0;
        load(63);
        n_cmp++; if (value60 !== 6'd0) begin n_bad++; $display("FAIL mod60_load63 got=%0d want=0", value60); end
        load(30);
        n_cmp++; if (value !== 6'd0 || value60 !== 6'd30) begin
            n_bad++; $display("FAIL load30 got=%0d/%0d want=0/30", value, value60);
        end
    endtask

    task automatic test_reset_mid_repeat();
        load(2);
        CH = 1'b0; tick();
        CH = 1'b1;
        for (int i = 0; i < 510; i++) tick();
        RST = 1'b1; tick();
        RST = 1'b0;
        for (int i = 0; i < 650; i++) tick();
        n_cmp++; if (value !== 6'd0) begin n_bad++; $display("FAIL reset_abort_repeat got=%0d want=0", value); end
        CH = 1'b0; tick();
        CH = 1'b1; tick();
        n_cmp++; if (value !== 6'd1) begin n_bad++; $display("FAIL reset_new_edge_step got=%0d want=1", value); end
        CH = 1'b0; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            RST      = ($urandom_range(0, 199) == 0);
            LOAD     = ($urandom_range(0, 39) == 0);
            LOAD_VAL = 6'($urandom_range(0, 63));
            CARRY    = 1'($urandom);
            ADJMODE  = 1'($urandom);
            if ($urandom_range(0, 7) == 0) CH = ~CH;
            if ($urandom_range(0, 15) == 0) STYLE = ~STYLE;
            tick();
            n_cmp++;
            if (value !== 6'(m_val[0]) || carry_out !== m_cout[0] || data !== m_data[0]) begin
                n_bad++;
                $display("FAIL random24 cyc=%0d got=%0d/%b/%h want=%0d/%b/%h",
                         i, value, carry_out, data, m_val[0], m_cout[0], m_data[0]);
            end
            n_cmp++;
            if (value60 !== 6'(m_val[1]) || carry_out60 !== m_cout[1] || data60 !== m_data[1]) begin
                n_bad++;
                $display("FAIL random60 cyc=%0d got=%0d/%b/%h want=%0d/%b/%h",
                         i, value60, carry_out60, data60, m_val[1], m_cout[1], m_data[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_adjust_down();
        test_auto_repeat();
        test_priority();
        test_style_sweep();
        test_mod60();
        test_reset_mid_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_unit_counter.md
TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

Interface
REQ-001 SHALL provide parameter MODULUS, default 24, count range 0..MODULUS-1 (legal 2..99).
REQ-002 SHALL provide parameter CW, default 6, width of the binary count; 2^CW >= MODULUS.
REQ-003 SHALL provide parameter AMPM_EN, default 1, which enables 12-hour display (effective only when MODULUS==24).
REQ-004 SHALL provide parameter REP_DLY, default 500, hold cycles before auto-repeat starts (>=2).
REQ-005 SHALL provide parameter REP_PER, default 100, cycles between auto-repeat steps (>=1).
REQ-006 CP  input  1  the only clock; all state updates on posedge CP.
REQ-007 RST  input  1  reset, synchronous and active-high.
REQ-008 CARRY  input  1  carry from the lower time unit; a rising edge is one increment.
REQ-009 CH  input  1  adjust request; rising edge gives one step, holding it gives auto-repeat.
REQ-010 ADJMODE  input  1  adjust direction, 0=up, 1=down; sampled at each step.
REQ-011 STYLE  input  1  display mode, 1=12-hour, 0=24-hour.
REQ-012 LOAD  input  1  synchronous load of LOAD_VAL.
REQ-013 LOAD_VAL  input  CW  load value; values >= MODULUS load 0.
REQ-014 value  output  CW  registered binary count.
REQ-015 data  output  16  registered display word {code[3:0], 4'hc, BCD tens, BCD ones}.
REQ-016 carry_out  output  1  registered one-cycle pulse on a carry-driven wrap.

Function
REQ-017 SHALL detect edges with registers carry_q and ch_q; carry event = CARRY & ~carry_q; ch event = CH & ~ch_q.
REQ-018 SHALL apply priority per cycle: RST > LOAD > carry event > adjust step; a lower-priority event in the same cycle is discarded.
REQ-019 A carry event SHALL set value to value+1, or to 0 when value==MODULUS-1, at the same edge.
REQ-020 carry_out SHALL be 1 in exactly the cycle in which value changes MODULUS-1->0 due to a carry event; it is 0 otherwise, including on adjust or load wraps.
REQ-021 An adjust step up SHALL wrap MODULUS-1->0; a step down SHALL wrap 0->MODULUS-1.
REQ-022 A ch event SHALL produce one adjust step at the same edge and clear the repeat counter rep_cnt.
REQ-023 While CH stays 1, rep_cnt SHALL count each cycle; a step occurs when rep_cnt reaches REP_DLY, and every REP_PER cycles after that.
REQ-024 CH==0 SHALL clear rep_cnt and stop the repeat immediately; no step occurs on release.
REQ-025 A step discarded under REQ-018 SHALL NOT reset or stall rep_cnt.
REQ-026 data SHALL be derived from value with one cycle of latency (data at cycle n+1 reflects value at cycle n).
REQ-027 24-hour mode, or 12-hour mode unavailable: code=4'hc, and the digits give BCD of value.
REQ-028 12-hour mode (STYLE=1, AMPM_EN=1, MODULUS=24): value<12 gives code 4'ha with digits value; value==12 gives code 4'hb with digits 12; value>12 gives code 4'hb with digits value-12.
REQ-029 data[11:8] SHALL always be 4'hc; tens and ones SHALL each be 0..9.

Reset
REQ-030 RST=1 SHALL set value=0, carry_out=0, rep_cnt=0, data={4'hc,4'hc,8'h00}.
REQ-031 RST SHALL set carry_q=1 and ch_q=1, so that inputs held high through reset generate no event.
REQ-032 RST asserted mid-repeat SHALL abort the repeat; after release a new CH rising edge is needed to step.

Verification
REQ-033 Value 23, one CARRY pulse -> value 0, carry_out high for exactly 1 cycle, data 0xCC00 one cycle later.
REQ-034 Value 0, ADJMODE=1, CH pulse -> value 23, carry_out stays 0; with STYLE=1, data becomes 0xBC11.
REQ-035 CH held 800 cycles with ADJMODE=0, REP_DLY=500, REP_PER=100, from 5 -> steps at hold cycles 0, 500, 600 and 700; final value 9.
REQ-036 CARRY event and CH event in the same cycle from 10 -> value 11 (adjust discarded).
REQ-037 STYLE=1 sweep over values 0, 11, 12, 13, 23 -> data 0xAC00, 0xAC11, 0xBC12, 0xBC01, 0xBC11.
REQ-038 MODULUS=60, CW=6: LOAD_VAL=59 then CARRY -> value 0 and carry_out pulses; LOAD_VAL=63 -> value 0.
